// File: rtl/simon_pkg.sv
// Shared constants, state encoding and rotate helpers for the SIMON-128/128
// sequencing controller and its round-step datapath.
package simon_pkg;

    localparam int SIMON_ROUNDS = 68;
    localparam int SIMON_WORD   = 64;

    // Key-schedule round constant c = 2^n - 4.
    localparam logic [63:0] SIMON_C = 64'hFFFF_FFFF_FFFF_FFFC;

    // z2 sequence, 62 bits long, consumed LSB-first (bit 0 feeds round 0's key step).
    localparam logic [63:0] SIMON_Z2_RAW = 64'h3369_F885_192C_0EF5;
    localparam logic [61:0] SIMON_Z2     = SIMON_Z2_RAW[61:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } simon_state_e;

    function automatic logic [63:0] rol64(input logic [63:0] v, input int unsigned n);
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

endpackage

// File: rtl/simon_round_step.sv
// One combinational SIMON-128/128 step: a Feistel round on {x, y} together with
// one step of the two-word key-expansion recurrence {ka, kb}.
module simon_round_step
    import simon_pkg::*;
(
    input  logic [63:0] x,
    input  logic [63:0] y,
    input  logic [63:0] ka,
    input  logic [63:0] kb,
    input  logic        zbit,
    output logic [63:0] x_nxt,
    output logic [63:0] y_nxt,
    output logic [63:0] ka_nxt,
    output logic [63:0] kb_nxt
);

    logic [63:0] f_x;

    // Round function f(x) = (x<<<1 & x<<<8) ^ x<<<2, then the Feistel swap.
    always_comb begin
        f_x   = (rol64(x, 1) & rol64(x, 8)) ^ rol64(x, 2);
        x_nxt = y ^ f_x ^ ka;
        y_nxt = x;
    end

    // Key recurrence: ka is consumed this round, kb slides down, new word enters at kb.
    always_comb begin
        ka_nxt = kb;
        kb_nxt = ka ^ ror64(kb, 3) ^ ror64(kb, 4) ^ SIMON_C ^ {63'd0, zbit};
    end

endmodule

// File: rtl/simon_enc_ctrl.sv
// Sequencing controller for SIMON-128/128 encryption with on-the-fly key expansion.
// Accepts {key, plaintext} on a valid/ready port, runs one round per cycle, and
// holds the ciphertext on a valid/ready output port until it is taken.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a job; in_ready high
// RUN   | one round per cycle, round_idx = 0..ROUNDS-1; busy high
// DONE  | ciphertext held on out_block with out_valid until out_ready
module simon_enc_ctrl
    import simon_pkg::*;
#(
    parameter int ROUNDS = SIMON_ROUNDS,
    parameter int WORD   = SIMON_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*WORD-1:0] in_key,
    input  logic [2*WORD-1:0] in_block,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*WORD-1:0] out_block,
    output logic              busy,
    output logic [6:0]        round_idx
);

    localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

    simon_state_e state, state_nxt;

    logic [63:0] x_q, y_q, ka_q, kb_q;
    logic [61:0] z_q;
    logic [6:0]  cnt_q;

    logic [63:0] x_nxt, y_nxt, ka_nxt, kb_nxt;
    logic        load_job;
    logic        step_round;

    simon_round_step u_step (
        .x      (x_q),
        .y      (y_q),
        .ka     (ka_q),
        .kb     (kb_q),
        .zbit   (z_q[0]),
        .x_nxt  (x_nxt),
        .y_nxt  (y_nxt),
        .ka_nxt (ka_nxt),
        .kb_nxt (kb_nxt)
    );

    // State register; reset discards any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake/status outputs.
    always_comb begin
        state_nxt  = state;
        load_job   = 1'b0;
        step_round = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        round_idx  = 7'd0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_job  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy       = 1'b1;
                round_idx  = cnt_q;
                step_round = 1'b1;
                if (cnt_q == LAST_ROUND) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Cipher state, key words, z sequence and round counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            ka_q  <= '0;
            kb_q  <= '0;
            z_q   <= '0;
            cnt_q <= '0;
        end else if (load_job) begin
            x_q   <= in_block[127:64];
            y_q   <= in_block[63:0];
            ka_q  <= in_key[63:0];
            kb_q  <= in_key[127:64];
            z_q   <= SIMON_Z2;
            cnt_q <= '0;
        end else if (step_round) begin
            x_q   <= x_nxt;
            y_q   <= y_nxt;
            ka_q  <= ka_nxt;
            kb_q  <= kb_nxt;
            z_q   <= {z_q[0], z_q[61:1]};
            cnt_q <= cnt_q + 7'd1;
        end
    end

    // Only DONE exposes the block meaningfully; it is frozen there because no step occurs.
    assign out_block = {x_q, y_q};

endmodule

// File: tb/tb_simon_enc_ctrl.sv
// Self-checking bench for simon_enc_ctrl: known-answer vector, backpressure,
// mid-run reset, back-to-back jobs, input isolation and random jobs against a
// behavioural SIMON-128/128 model.
module tb_simon_enc_ctrl;

    localparam int ROUNDS = 68;
    localparam logic [127:0] STD_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] STD_BLK = 128'h6373656420737265_6c6c657661727420;
    localparam logic [127:0] STD_CT  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_key;
    logic [127:0] in_block;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;
    logic [6:0]   round_idx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_q[$];
    logic [127:0] out_q[$];

    simon_enc_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .in_block  (in_block),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy),
        .round_idx (round_idx)
    );

    always #5 clk = ~clk;

    // Record accepted jobs (cycle stamp) and delivered ciphertexts.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (in_valid && in_ready) hs_q.push_back(cyc);
            if (out_valid && out_ready) out_q.push_back(out_block);
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [63:0] rl(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    // Textbook SIMON-128/128: expand the full key schedule, then run the Feistel rounds.
    function automatic logic [127:0] ref_enc(input logic [127:0] key, input logic [127:0] blk);
        logic [63:0] k[ROUNDS + 2];
        logic [63:0] z2;
        logic [63:0] x, y, t;
        z2 = 64'h3369F885192C0EF5;
        k[0] = key[63:0];
        k[1] = key[127:64];
        for (int i = 0; i < ROUNDS; i++)
            k[i + 2] = 64'hFFFFFFFFFFFFFFFC ^ {63'd0, z2[i % 62]} ^ k[i]
                       ^ rr(k[i + 1], 3) ^ rr(k[i + 1], 4);
        x = blk[127:64];
        y = blk[63:0];
        for (int i = 0; i < ROUNDS; i++) begin
            t = x;
            x = y ^ ((rl(x, 1) & rl(x, 8)) ^ rl(x, 2)) ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Full single job: handshake, watch RUN, stall for 'hold' cycles in DONE, release.
    task automatic run_job(input logic [127:0] key, input logic [127:0] blk,
                           input int hold, input bit jitter, input string tag);
        int n;
        int busy_n;
        int hs0;
        bit idx_ok;
        bit stall_ok;
        logic [127:0] exp;
        exp = ref_enc(key, blk);
        n = 0;
        while (!in_ready && n < 300) begin tick(); n++; end
        chk({tag, "_ready_wait"}, 128'(in_ready), 128'd1);
        hs0 = hs_q.size();
        in_key = key;
        in_block = blk;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        idx_ok = 1'b1;
        busy_n = 0;
        n = 0;
        while (!out_valid && n < 300) begin
            if (busy) busy_n++;
            if (!busy || round_idx != 7'(n)) idx_ok = 1'b0;
            if (jitter) begin
                in_valid = 1'($urandom_range(0, 1));
                in_key = rnd128();
                in_block = rnd128();
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 128'(n), 128'(ROUNDS));
        chk({tag, "_round_idx_seq"}, 128'(idx_ok), 128'd1);
        chk({tag, "_busy_cycles"}, 128'(busy_n), 128'(ROUNDS));
        chk({tag, "_out_block"}, out_block, exp);
        stall_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            tick();
            if (!out_valid || in_ready || busy || out_block !== exp) stall_ok = 1'b0;
        end
        chk({tag, "_stall_stable"}, 128'(stall_ok), 128'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_release_in_ready"}, 128'(in_ready), 128'd1);
        chk({tag, "_release_out_valid"}, 128'(out_valid), 128'd0);
        chk({tag, "_one_handshake"}, 128'(hs_q.size() - hs0), 128'd1);
        chk({tag, "_delivered"}, out_q[out_q.size() - 1], exp);
    endtask

    initial begin
        int n;
        int hs0;
        int oq0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_key = '0;
        in_block = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_round_idx", 128'(round_idx), 128'd0);
        chk("rst_out_block", out_block, 128'd0);
        rst = 1'b0;
        tick();

        // The model must reproduce the published known answer on its own.
        chk("model_kat", ref_enc(STD_KEY, STD_BLK), STD_CT);

        run_job(STD_KEY, STD_BLK, 0, 1'b0, "std");
        run_job(STD_KEY, STD_BLK, 10, 1'b0, "bp");

        // Reset in the middle of a run: no output may appear for the discarded job.
        oq0 = out_q.size();
        in_key = STD_KEY;
        in_block = STD_BLK;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (round_idx != 7'd30 && n < 200) begin tick(); n++; end
        chk("midrst_reach30", 128'(round_idx), 128'd30);
        rst = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_round_idx", 128'(round_idx), 128'd0);
        repeat (80) tick();
        chk("midrst_no_output", 128'(out_q.size() - oq0), 128'd0);
        run_job(STD_KEY, STD_BLK, 2, 1'b0, "after_rst");

        // Back-to-back with out_ready tied high.
        hs0 = hs_q.size();
        oq0 = out_q.size();
        out_ready = 1'b1;
        in_key = STD_KEY;
        in_block = STD_BLK;
        in_valid = 1'b1;
        tick();
        in_key = '0;
        in_block = '0;
        n = 0;
        while (hs_q.size() < hs0 + 2 && n < 300) begin tick(); n++; end
        in_valid = 1'b0;
        chk("b2b_two_accepts", 128'(hs_q.size() - hs0), 128'd2);
        n = 0;
        while (out_q.size() < oq0 + 2 && n < 300) begin tick(); n++; end
        out_ready = 1'b0;
        chk("b2b_two_outputs", 128'(out_q.size() - oq0), 128'd2);
        if (hs_q.size() >= hs0 + 2)
            chk("b2b_spacing", 128'(hs_q[hs0 + 1] - hs_q[hs0]), 128'(ROUNDS + 2));
        if (out_q.size() >= oq0 + 2) begin
            chk("b2b_first", out_q[oq0], STD_CT);
            chk("b2b_second", out_q[oq0 + 1], ref_enc(128'd0, 128'd0));
        end
        tick();

        run_job(STD_KEY, STD_BLK, 3, 1'b1, "isolate");
        tick();
        chk("isolate_idle_after", 128'(busy), 128'd0);

        for (int j = 0; j < 4; j++)
            run_job(rnd128(), rnd128(), int'($urandom_range(0, 4)), 1'(j % 2), "rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
